// File: rtl/ami_clk_pkg.sv
// ami_clk_pkg: shared lock states and CCK phase decode constants for Amiga clock recovery
package ami_clk_pkg;
    typedef enum logic [1:0] {HUNT, TRACK, LOCKED} lock_state_t;
    localparam int CCK_PHASES = 8;
    localparam logic [2:0] CCK_HIGH_END = 3'd4;
    localparam logic [2:0] CCKQ_FIRST = 3'd2;
    localparam logic [2:0] CCKQ_LAST = 3'd5;
    function automatic logic cckq_decode(input logic [2:0] ph);
        return (ph >= CCKQ_FIRST) && (ph <= CCKQ_LAST);
    endfunction
endpackage

// File: rtl/ami_edge_sync.sv
// ami_edge_sync: pad synchroniser with 4-deep history, emits registered rise/fall strobes ignoring pulses under 2 clk
module ami_edge_sync import ami_clk_pkg::*; #(
    parameter int SYNC_STAGES = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic [3:0] r_hist;
    logic r_rise;
    logic r_fall;
    // shift pad through the chain and history; edge needs two stable samples on each side
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_hist <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_hist <= {r_hist[2:0], r_sync[SYNC_STAGES-1]};
            r_rise <= (r_hist == 4'b0011);
            r_fall <= (r_hist == 4'b1100);
        end
    end
    assign o_rise = r_rise;
    assign o_fall = r_fall;
endmodule

// File: rtl/ami_clk_sync.sv
// ami_clk_sync: Amiga C7M/CDAC_n/CCK recovery, CCK phase tracking, lock detection and bus sync
// Optional macro AMI_CLK_SYNC_BUS_CAPTURE_EN: capture RGA/DB once per CCK at CAPTURE_PHASE while locked.
module ami_clk_sync import ami_clk_pkg::*; #(
    parameter int SYNC_STAGES   = 3,
    parameter int OSR           = 8,
    parameter int TOL           = 1,
    parameter int LOCK_CYCLES   = 4,
    parameter int RGA_W         = 8,
    parameter int DB_W          = 16,
    parameter int CAPTURE_PHASE = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_c7m,
    input  logic             i_cdac_n,
    input  logic             i_cck,
    input  logic [RGA_W-1:0] i_rga_in,
    input  logic [DB_W-1:0]  i_db_in,
    output logic             o_c7m_rise,
    output logic             o_c7m_fall,
    output logic             o_cdac_rise,
    output logic             o_cdac_fall,
    output logic             o_en_28m,
    output logic [2:0]       o_cck_phase,
    output logic             o_cck_out,
    output logic             o_cckq_out,
    output logic             o_locked,
    output logic             o_lock_err,
    output logic [RGA_W-1:0] o_rga_out,
    output logic [DB_W-1:0]  o_db_out,
    output logic             o_bus_valid
);
    localparam int PER_MAX = 4 * OSR;
    localparam int PER_W = $clog2(PER_MAX + 1);
    localparam int GOOD_W = $clog2(LOCK_CYCLES + 1);
    logic w_cck_rise, w_cck_fall, w_good, w_timeout;
    logic r_en, r_cdac_fall_d, r_cck_lvl, r_cck, r_cckq, r_locked, r_lock_err;
    logic [2:0] r_phase, w_phase_nxt;
    logic [PER_W-1:0] r_per_cnt;
    logic [3:0] r_edg_cnt;
    logic [GOOD_W-1:0] r_good_cnt, w_good_nxt;
    lock_state_t r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0][RGA_W-1:0] r_rga_s;
    logic [SYNC_STAGES-1:0][DB_W-1:0] r_db_s;
    ami_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_c7m (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_c7m), .o_rise(o_c7m_rise), .o_fall(o_c7m_fall));
    ami_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cdac (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_cdac_n), .o_rise(o_cdac_rise), .o_fall(o_cdac_fall));
    ami_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cck (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_cck), .o_rise(w_cck_rise), .o_fall(w_cck_fall));
    assign w_phase_nxt = !r_en ? r_phase : (r_cck_lvl && r_cdac_fall_d) ? 3'd0 : r_phase + 3'd1;
    assign w_good = (r_per_cnt >= PER_W'(2*OSR - TOL)) && (r_per_cnt <= PER_W'(2*OSR + TOL)) && (r_edg_cnt == 4'(CCK_PHASES));
    assign w_timeout = (r_per_cnt >= PER_W'(PER_MAX - 1));
    // lock FSM: one rise to start tracking, LOCK_CYCLES good periods to lock, any bad verdict drops to HUNT
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt = r_good_cnt;
        case (r_state)
            HUNT: if (w_cck_rise) begin
                w_state_nxt = TRACK;
                w_good_nxt = '0;
            end
            TRACK: if (w_cck_rise) begin
                w_state_nxt = !w_good ? HUNT : (r_good_cnt == GOOD_W'(LOCK_CYCLES - 1)) ? LOCKED : TRACK;
                w_good_nxt = r_good_cnt + GOOD_W'(1);
            end
            LOCKED: if ((w_cck_rise && !w_good) || w_timeout) w_state_nxt = HUNT;
            default: w_state_nxt = HUNT;
        endcase
    end
    // 28 MHz enable, phase counter with registered CCK/CCKQ decode, and period measurement
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_en <= 1'b0;
            r_cdac_fall_d <= 1'b0;
            r_cck_lvl <= 1'b0;
            r_phase <= '0;
            r_cck <= 1'b0;
            r_cckq <= 1'b0;
            r_per_cnt <= '0;
            r_edg_cnt <= '0;
            r_state <= HUNT;
            r_good_cnt <= '0;
            r_locked <= 1'b0;
            r_lock_err <= 1'b0;
        end else begin
            r_en <= o_c7m_rise | o_c7m_fall | o_cdac_rise | o_cdac_fall;
            r_cdac_fall_d <= o_cdac_fall;
            r_cck_lvl <= w_cck_rise ? 1'b1 : w_cck_fall ? 1'b0 : r_cck_lvl;
            r_phase <= w_phase_nxt;
            r_cck <= (w_phase_nxt < CCK_HIGH_END);
            r_cckq <= cckq_decode(w_phase_nxt);
            r_per_cnt <= w_cck_rise ? PER_W'(1) : (r_per_cnt == PER_W'(PER_MAX)) ? r_per_cnt : r_per_cnt + PER_W'(1);
            r_edg_cnt <= w_cck_rise ? 4'(r_en) : (r_edg_cnt == 4'hF) ? r_edg_cnt : r_edg_cnt + 4'(r_en);
            r_state <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
            r_locked <= (w_state_nxt == LOCKED);
            r_lock_err <= (r_state == LOCKED) && (w_state_nxt == HUNT);
        end
    end
    // plain multi-stage synchronisers for the address and data buses
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rga_s <= '0;
            r_db_s <= '0;
        end else begin
            r_rga_s <= {r_rga_s[SYNC_STAGES-2:0], i_rga_in};
            r_db_s <= {r_db_s[SYNC_STAGES-2:0], i_db_in};
        end
    end
`ifdef AMI_CLK_SYNC_BUS_CAPTURE_EN
    logic w_cap, r_bus_valid;
    logic [RGA_W-1:0] r_rga;
    logic [DB_W-1:0] r_db;
    assign w_cap = r_en && r_locked && (w_phase_nxt == 3'(CAPTURE_PHASE));
    // sample the synchronised buses once per CCK period at the capture phase
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bus_valid <= 1'b0;
            r_rga <= '0;
            r_db <= '0;
        end else begin
            r_bus_valid <= w_cap;
            if (w_cap) begin
                r_rga <= r_rga_s[SYNC_STAGES-1];
                r_db <= r_db_s[SYNC_STAGES-1];
            end
        end
    end
    assign o_rga_out = r_rga;
    assign o_db_out = r_db;
    assign o_bus_valid = r_bus_valid;
`else
    assign o_rga_out = r_rga_s[SYNC_STAGES-1];
    assign o_db_out = r_db_s[SYNC_STAGES-1];
    assign o_bus_valid = 1'b1;
`endif
    assign o_en_28m = r_en;
    assign o_cck_phase = r_phase;
    assign o_cck_out = r_cck;
    assign o_cckq_out = r_cckq;
    assign o_locked = r_locked;
    assign o_lock_err = r_lock_err;
endmodule
